mac_dot_sequencer: RTL and testbench
====================================

Name: mac_dot_sequencer

Overview:
- Sequential initiator for the MAC datapath. It accepts a job length, then streams operand pairs over a valid/ready handshake and accumulates their products in a registered full-width accumulator.
- It returns a single dot-product result through an output handshake.
- It replaces the manual feedback of accumulator output into accumulator input with hardware sequencing, and sits between an operand source (buffer/DMA) and a result consumer.

Parameters:
- DATA_W, 16, operand width of A and B (unsigned)
- ACC_W, 32, accumulator/result width; must be >= 2*DATA_W
- LEN_W, 8, width of job-length field (max 2^LEN_W-1 pairs)

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- start  input  1  job request; sampled only in IDLE
- len  input  LEN_W  number of operand pairs; sampled with start
- op_valid  input  1  operand pair valid
- op_ready  output  1  sequencer accepts pair this cycle
- op_a  input  DATA_W  operand A
- op_b  input  DATA_W  operand B
- res_valid  output  1  result available
- res_ready  input  1  consumer accepts result
- res_data  output  ACC_W  accumulated result
- res_overflow  output  1  sticky: accumulator carried out of ACC_W during job
- busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (sync, rst=1 at edge): state=IDLE, acc=0, count=0, prod_q=0, prod_v=0, overflow=0. All outputs read 0 the next cycle: op_ready, res_valid, res_data, res_overflow, busy. Reset mid-job abandons the job; no partial result is emitted.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - start=1 and len!=0: latch len, clear acc/count/overflow, go to RUN.
  - start=1 and len=0: clear acc, go to DONE (res_data=0 on the next cycle).
  - start outside IDLE is ignored.
- RUN: op_ready=1 while count<len. A beat transfers when op_valid && op_ready.
  - Each beat: prod_q <= op_a*op_b (unsigned, 2*DATA_W, zero-extended to ACC_W), prod_v<=1, count++.
  - Every cycle with prod_v=1: acc <= acc+prod_q, modulo 2^ACC_W. A carry out sets overflow (sticky until the next start or rst).
  - Last beat (count==len-1 at transfer): go to DRAIN; op_ready=0 from the next cycle.
  - Gaps in op_valid are allowed; acc updates only from valid products.
- DRAIN: one cycle; the final prod_q is added to acc; go to DONE.
- DONE: res_valid=1, res_data=acc, res_overflow=overflow; all held stable until res_ready=1. Handshake cycle: go to IDLE, res_valid=0 next cycle.
- Latency: res_valid asserts exactly 2 cycles after the last operand handshake. Throughput: 1 pair/cycle.
- op_ready is a registered-state function only (no combinational path from op_valid). res_valid does not depend on res_ready.
- busy=1 in RUN, DRAIN and DONE.

Decomposition:
- Shared package mac_pkg:
  - state enum (IDLE/RUN/DRAIN/DONE)
  - default DATA_W/ACC_W/LEN_W constants
- One sub-module, mac_acc_stage: registered multiply (prod_q/prod_v) plus accumulate with carry-out.
- The top holds the FSM, the counter and the handshakes.

Test Plan:
- len=3, pairs (5,6),(2,3),(8,9) back-to-back -> op_ready high 3 cycles; res_valid 2 cycles after third beat; res_data=0x0000006C, res_overflow=0.
- Same job with op_valid deasserted 2 cycles between beats -> res_data=0x0000006C; no extra accumulation during gaps.
- len=2, pairs (0xFFFF,0xFFFF)x2 -> res_data=0xFFFC0002, res_overflow=1; next job len=1 (1,1) -> res_data=0x00000001, res_overflow=0.
- start with len=0 -> op_ready never asserts; res_valid the next cycle with res_data=0.
- res_ready held low 5 cycles in DONE with start pulsed -> res_data stable, start ignored, busy=1; after handshake, IDLE next cycle.
- rst asserted after 2 of 4 beats -> next cycle all outputs 0, state IDLE; new job len=1 (7,7) -> res_data=0x00000031.

Source files
------------

// File: rtl/mac_pkg.sv
// Shared types and default widths for the MAC dot-product sequencer.
package mac_pkg;

  localparam int unsigned DefDataW = 16;
  localparam int unsigned DefAccW  = 32;
  localparam int unsigned DefLenW  = 8;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain,
    StDone
  } state_e;

endpackage

// File: rtl/mac_acc_stage.sv
// Registered unsigned multiply followed by a full-width accumulate with sticky carry-out.
module mac_acc_stage
  import mac_pkg::*;
#(
  parameter int unsigned DATA_W = DefDataW,
  parameter int unsigned ACC_W  = DefAccW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [ACC_W-1:0]  acc,
  output logic              overflow
);

  logic [2*DATA_W-1:0] prod_q;
  logic                prod_v;
  logic [ACC_W:0]      sum;

  // One extra bit captures the carry out of the accumulator.
  assign sum = {1'b0, acc} + (ACC_W + 1)'(prod_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      prod_q   <= '0;
      prod_v   <= 1'b0;
      acc      <= '0;
      overflow <= 1'b0;
    end else begin
      prod_v <= in_valid;
      if (in_valid) begin
        prod_q <= {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};
      end
      if (clear) begin
        acc      <= '0;
        overflow <= 1'b0;
      end else if (prod_v) begin
        acc      <= sum[ACC_W-1:0];
        overflow <= overflow | sum[ACC_W];
      end
    end
  end

endmodule

// File: rtl/mac_dot_sequencer.sv
// Job sequencer: takes a length, streams operand pairs into the MAC stage, returns one dot product.
module mac_dot_sequencer
  import mac_pkg::*;
#(
  parameter int unsigned DATA_W = DefDataW,
  parameter int unsigned ACC_W  = DefAccW,
  parameter int unsigned LEN_W  = DefLenW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [ACC_W-1:0]  res_data,
  output logic              res_overflow,
  output logic              busy
);

  state_e           state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] count_q, count_d;
  logic             clear;
  logic             beat;
  logic [ACC_W-1:0] acc;
  logic             acc_overflow;

  mac_acc_stage #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) u_acc_stage (
    .clk      (clk),
    .rst      (rst),
    .clear    (clear),
    .in_valid (beat),
    .a        (op_a),
    .b        (op_b),
    .acc      (acc),
    .overflow (acc_overflow)
  );

  // op_ready depends on registered state only, never on op_valid.
  assign op_ready = (state_q == StRun) && (count_q < len_q);
  assign beat     = op_valid && op_ready;

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    count_d = count_q;
    clear   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          clear   = 1'b1;
          count_d = '0;
          if (len != '0) begin
            len_d   = len;
            state_d = StRun;
          end else begin
            state_d = StDone;
          end
        end
      end
      StRun: begin
        if (beat) begin
          count_d = count_q + LEN_W'(1);
          if (count_q == len_q - LEN_W'(1)) begin
            state_d = StDrain;
          end
        end
      end
      StDrain: state_d = StDone;
      StDone: begin
        if (res_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      len_q   <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    res_valid    = (state_q == StDone);
    busy         = (state_q != StIdle);
    res_data     = res_valid ? acc : '0;
    res_overflow = res_valid ? acc_overflow : 1'b0;
  end

endmodule

// File: tb/tb_mac_dot_sequencer.sv
// Directed plus randomized jobs against a sum-of-products reference model.
module tb_mac_dot_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  len = '0;
  logic        op_valid = 1'b0;
  logic        op_ready;
  logic [15:0] op_a = '0;
  logic [15:0] op_b = '0;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [31:0] res_data;
  logic        res_overflow;
  logic        busy;

  int n_cmp = 0;
  int n_bad = 0;
  logic [15:0] qa[$];
  logic [15:0] qb[$];

  always #5 clk = ~clk;

  mac_dot_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .len          (len),
    .op_valid     (op_valid),
    .op_ready     (op_ready),
    .op_a         (op_a),
    .op_b         (op_b),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_data     (res_data),
    .res_overflow (res_overflow),
    .busy         (busy)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, ".op_ready"}, 64'(op_ready), 64'd0);
    check({tag, ".res_valid"}, 64'(res_valid), 64'd0);
    check({tag, ".res_data"}, 64'(res_data), 64'd0);
    check({tag, ".res_overflow"}, 64'(res_overflow), 64'd0);
    check({tag, ".busy"}, 64'(busy), 64'd0);
  endtask

  // Runs the job held in qa/qb. gap_mode < 0 picks random gaps per beat.
  task automatic run_job(input string tag, input int gap_mode, input int hold, input bit poke);
    longint unsigned sum = 0;
    int n = qa.size();
    int rdy_cycles = 0;
    int gap_total = 0;
    int g;
    logic [31:0] exp_data;
    logic        exp_ovf;
    for (int i = 0; i < n; i++) sum += longint'(qa[i]) * longint'(qb[i]);
    exp_data = sum[31:0];
    exp_ovf  = (sum >> 32) != 0;

    start = 1'b1;
    len   = 8'(n);
    step();
    start = 1'b0;
    len   = 8'($urandom);
    if (n == 0) begin
      check({tag, ".len0_ready"}, 64'(op_ready), 64'd0);
    end else begin
      for (int i = 0; i < n; i++) begin
        g = (gap_mode < 0) ? int'($urandom_range(0, 2)) : gap_mode;
        gap_total += g;
        op_valid = 1'b0;
        op_a = 16'($urandom);
        op_b = 16'($urandom);
        repeat (g) begin
          if (op_ready) rdy_cycles++;
          step();
        end
        op_valid = 1'b1;
        op_a = qa[i];
        op_b = qb[i];
        if (op_ready) rdy_cycles++;
        step();
      end
      op_valid = 1'b0;
      check({tag, ".ready_cycles"}, 64'(rdy_cycles), 64'(n + gap_total));
      check({tag, ".drain_ready"}, 64'(op_ready), 64'd0);
      check({tag, ".drain_valid"}, 64'(res_valid), 64'd0);
      step();
    end
    check({tag, ".res_valid"}, 64'(res_valid), 64'd1);
    check({tag, ".res_data"}, 64'(res_data), 64'(exp_data));
    check({tag, ".res_overflow"}, 64'(res_overflow), 64'(exp_ovf));
    check({tag, ".busy"}, 64'(busy), 64'd1);

    for (int h = 0; h < hold; h++) begin
      start = poke;
      len   = 8'd5;
      step();
      check({tag, ".hold_valid"}, 64'(res_valid), 64'd1);
      check({tag, ".hold_data"}, 64'(res_data), 64'(exp_data));
      check({tag, ".hold_busy"}, 64'(busy), 64'd1);
      check({tag, ".hold_ready"}, 64'(op_ready), 64'd0);
    end
    start = 1'b0;
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    check({tag, ".after_valid"}, 64'(res_valid), 64'd0);
    check({tag, ".after_busy"}, 64'(busy), 64'd0);
  endtask

  initial begin
    int n;
    bool_big: begin end
    repeat (2) step();
    check_idle_zero("reset");
    rst = 1'b0;
    step();

    qa = '{16'd5, 16'd2, 16'd8};
    qb = '{16'd6, 16'd3, 16'd9};
    run_job("b2b", 0, 0, 1'b0);
    run_job("gap2", 2, 0, 1'b0);

    qa = '{16'hFFFF, 16'hFFFF};
    qb = '{16'hFFFF, 16'hFFFF};
    run_job("ovf", 0, 1, 1'b0);
    qa = '{16'd1};
    qb = '{16'd1};
    run_job("ovf_clr", 0, 0, 1'b0);

    qa.delete();
    qb.delete();
    run_job("len0", 0, 0, 1'b0);

    qa = '{16'd5, 16'd2, 16'd8};
    qb = '{16'd6, 16'd3, 16'd9};
    run_job("hold", 0, 5, 1'b1);

    // Abandon a 4-beat job after two beats.
    start = 1'b1;
    len   = 8'd4;
    step();
    start = 1'b0;
    op_valid = 1'b1;
    op_a = 16'd3;
    op_b = 16'd4;
    repeat (2) step();
    op_valid = 1'b0;
    rst = 1'b1;
    step();
    check_idle_zero("midrst");
    rst = 1'b0;
    step();
    check("midrst.idle_busy", 64'(busy), 64'd0);
    qa = '{16'd7};
    qb = '{16'd7};
    run_job("post_rst", 0, 0, 1'b0);

    for (int j = 0; j < 12; j++) begin
      qa.delete();
      qb.delete();
      n = int'($urandom_range(1, 12));
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 2) == 0) begin
          qa.push_back(16'($urandom_range(16'hF000, 16'hFFFF)));
          qb.push_back(16'($urandom_range(16'hF000, 16'hFFFF)));
        end else begin
          qa.push_back(16'($urandom));
          qb.push_back(16'($urandom));
        end
      end
      run_job($sformatf("rnd%0d", j), -1, int'($urandom_range(0, 3)), 1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
